permute_lane_collector: RTL

- Downstream stage of the permutation control unit.
- Captures one 25-bit state slice each time the permutation datapath signals a finished slice (CU `ready` pulse). Repeats for all 64 slices of a round.
- Then transposes slice order to lane order: 25 lanes x 64 bits.
- Drains the lanes one per handshake to the output writer, and pulses `done` when the full 1600-bit state has been delivered.

---
 rtl/permute_lane_collector.sv | 113 +++++++++++
 1 files changed

// File: rtl/permute_lane_collector.sv
// Collects SLICES slice words from the permutation datapath, then drains them transposed as LANES lane words.
// One slice per clock in, one lane per out_valid/out_ready handshake out; done pulses after the last lane.
module permute_lane_collector #(
  parameter int SLICES = 64,
  parameter int LANES  = 25,
  parameter int SW     = 6,
  parameter int LW     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              slice_valid,
  input  logic [LANES-1:0]  slice_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              out_valid,
  output logic [LW-1:0]     out_lane,
  output logic [SLICES-1:0] out_data,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN} state_t;

  state_t             r_state, w_state_nxt;
  logic [SW-1:0]      r_cnt, w_cnt_nxt;
  logic [LW-1:0]      r_lane, w_lane_nxt;
  logic               r_done, w_done_nxt;
  logic               r_err, w_err_nxt;
  logic               w_wr;
  logic [LANES-1:0]   r_buf [SLICES];
  logic [SLICES-1:0]  w_lane_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_lane  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_lane  <= w_lane_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Slice storage carries no reset; it is fully overwritten before every drain.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_buf[r_cnt] <= slice_data;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_lane_nxt  = r_lane;
    w_done_nxt  = 1'b0;
    w_err_nxt   = r_err | (slice_valid && (r_state != S_COLLECT));
    w_wr        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_COLLECT;
          w_cnt_nxt   = '0;
        end
      end
      S_COLLECT: begin
        if (slice_valid) begin
          w_wr = 1'b1;
          if (r_cnt == SW'(SLICES - 1)) begin
            w_cnt_nxt   = '0;
            w_lane_nxt  = '0;
            w_state_nxt = S_DRAIN;
          end else begin
            w_cnt_nxt = r_cnt + SW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (r_lane == LW'(LANES - 1)) begin
            w_lane_nxt  = '0;
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_lane_nxt = r_lane + LW'(1);
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Transpose: bit z of the lane word is this lane's bit from slice z.
  always_comb begin
    w_lane_word = '0;
    for (int z = 0; z < SLICES; z++) begin
      w_lane_word[z] = r_buf[z][r_lane];
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign out_valid = (r_state == S_DRAIN);
  assign out_lane  = r_lane;
  assign out_data  = out_valid ? w_lane_word : '0;
  assign done      = r_done;
  assign err       = r_err;

endmodule
